ex_stage: RTL and testbench

- Execute stage of the five-stage MIPS pipeline: consumer of the decode stage's ex-bound bundle (aluop, alusel, reg1, reg2, wd, wreg, return_addr, inst, pc).
- Contains the ID/EX pipeline register, the ALU, and the EX/MEM pipeline register.
- Drives the ex-stage forwarding triple back to decode and a load-use hazard flag for decode's stallreq.

---
 rtl/ex_stage.sv | 203 ++++++++++++++++++++
 tb/tb_ex_stage.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the five-stage MIPS pipeline.
// Holds the ID/EX register, the ALU, and the EX/MEM register, and feeds forwarding/hazard info back to decode.
`default_nettype none

module ex_stage #(
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int OPW  = 8,
  parameter int SELW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_id_i,
  input  logic            stall_ex_i,
  input  logic            flush_i,
  input  logic [OPW-1:0]  id_aluop_i,
  input  logic [SELW-1:0] id_alusel_i,
  input  logic [DW-1:0]   id_reg1_i,
  input  logic [DW-1:0]   id_reg2_i,
  input  logic [AW-1:0]   id_wd_i,
  input  logic            id_wreg_i,
  input  logic [DW-1:0]   id_return_addr_i,
  input  logic [DW-1:0]   id_inst_i,
  input  logic [DW-1:0]   id_pc_i,
  output logic            ex_wreg_o,
  output logic [AW-1:0]   ex_wd_o,
  output logic [DW-1:0]   ex_wdata_o,
  output logic            ex_is_load_o,
  output logic            mem_wreg_o,
  output logic [AW-1:0]   mem_wd_o,
  output logic [DW-1:0]   mem_wdata_o,
  output logic [OPW-1:0]  mem_aluop_o,
  output logic [DW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_sdata_o,
  output logic [DW-1:0]   mem_pc_o,
  output logic            ovf_o
);

  localparam logic [OPW-1:0] OP_NOP   = OPW'(8'b0000_0000);
  localparam logic [OPW-1:0] OP_OR    = OPW'(8'b0010_0101);
  localparam logic [OPW-1:0] OP_AND   = OPW'(8'b0010_0100);
  localparam logic [OPW-1:0] OP_XOR   = OPW'(8'b0010_0110);
  localparam logic [OPW-1:0] OP_NOR   = OPW'(8'b0010_0111);
  localparam logic [OPW-1:0] OP_LUI   = OPW'(8'b0101_1100);
  localparam logic [OPW-1:0] OP_SLL   = OPW'(8'b0111_1100);
  localparam logic [OPW-1:0] OP_SRL   = OPW'(8'b0000_0010);
  localparam logic [OPW-1:0] OP_SRA   = OPW'(8'b0000_0011);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(8'b0010_0000);
  localparam logic [OPW-1:0] OP_ADDU  = OPW'(8'b0010_0001);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(8'b0010_0010);
  localparam logic [OPW-1:0] OP_SUBU  = OPW'(8'b0010_0011);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(8'b0101_0101);
  localparam logic [OPW-1:0] OP_ADDIU = OPW'(8'b0101_0110);
  localparam logic [OPW-1:0] OP_SLT   = OPW'(8'b0010_1010);
  localparam logic [OPW-1:0] OP_SLTU  = OPW'(8'b0010_1011);
  localparam logic [OPW-1:0] OP_MOVZ  = OPW'(8'b0000_1010);
  localparam logic [OPW-1:0] OP_MOVN  = OPW'(8'b0000_1011);
  localparam logic [OPW-1:0] OP_LB    = OPW'(8'b1110_0000);
  localparam logic [OPW-1:0] OP_LH    = OPW'(8'b1110_0001);
  localparam logic [OPW-1:0] OP_LW    = OPW'(8'b1110_0011);
  localparam logic [OPW-1:0] OP_SB    = OPW'(8'b1110_1000);
  localparam logic [OPW-1:0] OP_SH    = OPW'(8'b1110_1001);
  localparam logic [OPW-1:0] OP_SW    = OPW'(8'b1110_1011);

  localparam logic [SELW-1:0] SEL_NOP  = SELW'(3'b000);
  localparam logic [SELW-1:0] SEL_JUMP = SELW'(3'b110);

  logic [OPW-1:0]  idex_aluop;
  logic [SELW-1:0] idex_alusel;
  logic [DW-1:0]   idex_reg1;
  logic [DW-1:0]   idex_reg2;
  logic [AW-1:0]   idex_wd;
  logic            idex_wreg;
  logic [DW-1:0]   idex_ra;
  logic [15:0]     idex_imm;
  logic [DW-1:0]   idex_pc;

  // Only the immediate field of the instruction word is consumed here.
  logic unused_inst;
  assign unused_inst = &{1'b0, id_inst_i[DW-1:16]};

  always_ff @(posedge clk) begin
    if (rst || flush_i || (stall_id_i && !stall_ex_i)) begin
      idex_aluop  <= OP_NOP;
      idex_alusel <= SEL_NOP;
      idex_reg1   <= '0;
      idex_reg2   <= '0;
      idex_wd     <= '0;
      idex_wreg   <= 1'b0;
      idex_ra     <= '0;
      idex_imm    <= '0;
      idex_pc     <= '0;
    end else if (!stall_ex_i) begin
      idex_aluop  <= id_aluop_i;
      idex_alusel <= id_alusel_i;
      idex_reg1   <= id_reg1_i;
      idex_reg2   <= id_reg2_i;
      idex_wd     <= id_wd_i;
      idex_wreg   <= id_wreg_i;
      idex_ra     <= id_return_addr_i;
      idex_imm    <= id_inst_i[15:0];
      idex_pc     <= id_pc_i;
    end
  end

  logic [4:0]    sh;
  logic [DW-1:0] sum;
  logic [DW-1:0] diff;
  logic [DW-1:0] addr;
  logic [DW-1:0] res;
  logic          known;
  logic          ovf;
  logic          mov_ok;
  logic          slt;
  logic          sltu;

  assign sh   = idex_reg1[4:0];
  assign sum  = idex_reg1 + idex_reg2;
  assign diff = idex_reg1 - idex_reg2;
  assign addr = idex_reg1 + {{(DW-16){idex_imm[15]}}, idex_imm};
  assign slt  = $signed(idex_reg1) < $signed(idex_reg2);
  assign sltu = idex_reg1 < idex_reg2;

  always_comb begin
    res    = '0;
    known  = 1'b1;
    ovf    = 1'b0;
    mov_ok = 1'b1;
    case (idex_aluop)
      OP_OR:            res = idex_reg1 | idex_reg2;
      OP_AND:           res = idex_reg1 & idex_reg2;
      OP_XOR:           res = idex_reg1 ^ idex_reg2;
      OP_NOR:           res = ~(idex_reg1 | idex_reg2);
      OP_LUI:           res = idex_reg2;
      OP_SLL:           res = idex_reg2 << sh;
      OP_SRL:           res = idex_reg2 >> sh;
      OP_SRA:           res = $unsigned($signed(idex_reg2) >>> sh);
      OP_ADD, OP_ADDI: begin
        res = sum;
        ovf = (idex_reg1[DW-1] == idex_reg2[DW-1]) && (sum[DW-1] != idex_reg1[DW-1]);
      end
      OP_ADDU, OP_ADDIU: res = sum;
      OP_SUB: begin
        res = diff;
        ovf = (idex_reg1[DW-1] != idex_reg2[DW-1]) && (diff[DW-1] != idex_reg1[DW-1]);
      end
      OP_SUBU:          res = diff;
      OP_SLT:           res = {{(DW-1){1'b0}}, slt};
      OP_SLTU:          res = {{(DW-1){1'b0}}, sltu};
      OP_MOVN: begin
        res    = idex_reg1;
        mov_ok = |idex_reg2;
      end
      OP_MOVZ: begin
        res    = idex_reg1;
        mov_ok = ~|idex_reg2;
      end
      OP_LB, OP_LH, OP_LW, OP_SB, OP_SH, OP_SW: res = '0;
      default:          known = 1'b0;
    endcase
    // The result class overrides the opcode decode for links and bubbles.
    if (idex_alusel == SEL_JUMP) begin
      res    = idex_ra;
      known  = 1'b1;
      ovf    = 1'b0;
      mov_ok = 1'b1;
    end else if (idex_alusel == SEL_NOP) begin
      known = 1'b0;
      ovf   = 1'b0;
    end
    if (!known) res = '0;
  end

  assign ex_wreg_o    = idex_wreg && known && mov_ok && !ovf;
  assign ex_wd_o      = idex_wd;
  assign ex_wdata_o   = res;
  assign ex_is_load_o = (idex_aluop == OP_LW) || (idex_aluop == OP_LB) || (idex_aluop == OP_LH);

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      mem_wreg_o  <= 1'b0;
      mem_wd_o    <= '0;
      mem_wdata_o <= '0;
      mem_aluop_o <= OP_NOP;
      mem_addr_o  <= '0;
      mem_sdata_o <= '0;
      mem_pc_o    <= '0;
      ovf_o       <= 1'b0;
    end else if (!stall_ex_i) begin
      mem_wreg_o  <= ex_wreg_o;
      mem_wd_o    <= idex_wd;
      mem_wdata_o <= res;
      mem_aluop_o <= idex_aluop;
      mem_addr_o  <= addr;
      mem_sdata_o <= idex_reg2;
      mem_pc_o    <= idex_pc;
      ovf_o       <= ovf;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed and randomized checks of ex_stage against a transaction-level model.
`default_nettype none

module tb_ex_stage;

  localparam logic [7:0] OP_NOP = 8'h00, OP_OR = 8'h25, OP_AND = 8'h24, OP_XOR = 8'h26,
    OP_NOR = 8'h27, OP_LUI = 8'h5C, OP_SLL = 8'h7C, OP_SRL = 8'h02, OP_SRA = 8'h03,
    OP_ADD = 8'h20, OP_ADDU = 8'h21, OP_SUB = 8'h22, OP_SUBU = 8'h23, OP_ADDI = 8'h55,
    OP_ADDIU = 8'h56, OP_SLT = 8'h2A, OP_SLTU = 8'h2B, OP_MOVZ = 8'h0A, OP_MOVN = 8'h0B,
    OP_LB = 8'hE0, OP_LH = 8'hE1, OP_LW = 8'hE3, OP_SB = 8'hE8, OP_SH = 8'hE9, OP_SW = 8'hEB,
    OP_JAL = 8'h50, OP_BAD = 8'hFF;
  localparam logic [2:0] SEL_NOP = 3'd0, SEL_LOGIC = 3'd1, SEL_SHIFT = 3'd2, SEL_MOVE = 3'd3,
    SEL_ARITH = 3'd4, SEL_JUMP = 3'd6, SEL_LS = 3'd7;

  typedef struct {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1, reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] ra, inst, pc;
  } bundle_t;

  typedef struct {
    logic        wreg;
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic [7:0]  aluop;
    logic [31:0] addr, sdata, pc;
    logic        ovf;
  } slot_t;

  logic clk = 1'b0;
  logic rst = 1'b1, stall_id = 1'b0, stall_ex = 1'b0, flush = 1'b0;
  bundle_t in_b = '{aluop: OP_NOP, alusel: SEL_NOP, default: '0};

  logic        ex_wreg, ex_is_load, mem_wreg, ovf;
  logic [4:0]  ex_wd, mem_wd;
  logic [31:0] ex_wdata, mem_wdata, mem_addr, mem_sdata, mem_pc;
  logic [7:0]  mem_aluop;

  int n_cmp = 0;
  int n_err = 0;

  bundle_t m_idex;
  slot_t   m_mem;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst), .stall_id_i(stall_id), .stall_ex_i(stall_ex), .flush_i(flush),
    .id_aluop_i(in_b.aluop), .id_alusel_i(in_b.alusel), .id_reg1_i(in_b.reg1),
    .id_reg2_i(in_b.reg2), .id_wd_i(in_b.wd), .id_wreg_i(in_b.wreg),
    .id_return_addr_i(in_b.ra), .id_inst_i(in_b.inst), .id_pc_i(in_b.pc),
    .ex_wreg_o(ex_wreg), .ex_wd_o(ex_wd), .ex_wdata_o(ex_wdata), .ex_is_load_o(ex_is_load),
    .mem_wreg_o(mem_wreg), .mem_wd_o(mem_wd), .mem_wdata_o(mem_wdata), .mem_aluop_o(mem_aluop),
    .mem_addr_o(mem_addr), .mem_sdata_o(mem_sdata), .mem_pc_o(mem_pc), .ovf_o(ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bundle_t bubble();
    bundle_t b = '{aluop: OP_NOP, alusel: SEL_NOP, default: '0};
    return b;
  endfunction

  // Expected slot contents from the instruction semantics, using wide signed arithmetic.
  function automatic slot_t exec(input bundle_t b);
    slot_t  s;
    longint a, c, r;
    int     k;
    a = longint'($signed(b.reg1));
    c = longint'($signed(b.reg2));
    k = int'(b.reg1[4:0]);
    s.wd = b.wd; s.aluop = b.aluop; s.pc = b.pc; s.sdata = b.reg2;
    s.addr = b.reg1 + {{16{b.inst[15]}}, b.inst[15:0]};
    s.ovf = 1'b0; s.wdata = 32'h0; s.wreg = b.wreg;
    if (b.alusel == SEL_NOP) s.wreg = 1'b0;
    else if (b.alusel == SEL_JUMP) s.wdata = b.ra;
    else begin
      case (b.aluop)
        OP_OR:  s.wdata = b.reg1 | b.reg2;
        OP_AND: s.wdata = b.reg1 & b.reg2;
        OP_XOR: s.wdata = b.reg1 ^ b.reg2;
        OP_NOR: s.wdata = ~(b.reg1 | b.reg2);
        OP_LUI: s.wdata = b.reg2;
        OP_SLL: s.wdata = 32'((64'(b.reg2) * (64'd1 << k)));
        OP_SRL: s.wdata = 32'(64'(b.reg2) / (64'd1 << k));
        OP_SRA: begin
          r = c;
          for (int i = 0; i < k; i++) r = (r < 0) ? -((-r + 1) / 2) : r / 2;
          s.wdata = r[31:0];
        end
        OP_ADD, OP_ADDI, OP_SUB: begin
          r = (b.aluop == OP_SUB) ? a - c : a + c;
          s.wdata = r[31:0];
          s.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
          if (s.ovf) s.wreg = 1'b0;
        end
        OP_ADDU, OP_ADDIU: s.wdata = b.reg1 + b.reg2;
        OP_SUBU: s.wdata = b.reg1 - b.reg2;
        OP_SLT:  s.wdata = (a < c) ? 32'd1 : 32'd0;
        OP_SLTU: s.wdata = ({32'h0, b.reg1} < {32'h0, b.reg2}) ? 32'd1 : 32'd0;
        OP_MOVN: begin s.wdata = b.reg1; if (b.reg2 == 0) s.wreg = 1'b0; end
        OP_MOVZ: begin s.wdata = b.reg1; if (b.reg2 != 0) s.wreg = 1'b0; end
        OP_LB, OP_LH, OP_LW, OP_SB, OP_SH, OP_SW: s.wdata = 32'h0;
        default: s.wreg = 1'b0;
      endcase
    end
    return s;
  endfunction

  task automatic compare_all();
    slot_t e;
    e = exec(m_idex);
    check("ex_wreg",    32'(ex_wreg),    32'(e.wreg));
    check("ex_wd",      32'(ex_wd),      32'(e.wd));
    check("ex_wdata",   ex_wdata,        e.wdata);
    check("ex_is_load", 32'(ex_is_load),
          32'(m_idex.aluop == OP_LW || m_idex.aluop == OP_LB || m_idex.aluop == OP_LH));
    check("mem_wreg",   32'(mem_wreg),   32'(m_mem.wreg));
    check("mem_wd",     32'(mem_wd),     32'(m_mem.wd));
    check("mem_wdata",  mem_wdata,       m_mem.wdata);
    check("mem_aluop",  32'(mem_aluop),  32'(m_mem.aluop));
    check("mem_addr",   mem_addr,        m_mem.addr);
    check("mem_sdata",  mem_sdata,       m_mem.sdata);
    check("mem_pc",     mem_pc,          m_mem.pc);
    check("ovf",        32'(ovf),        32'(m_mem.ovf));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst || flush) begin
      m_idex = bubble();
      m_mem  = exec(bubble());
    end else if (!stall_ex) begin
      m_mem  = exec(m_idex);
      m_idex = stall_id ? bubble() : in_b;
    end
    #1;
    compare_all();
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [4:0] wd, input logic [31:0] inst);
    in_b.aluop = op; in_b.alusel = sel; in_b.reg1 = r1; in_b.reg2 = r2; in_b.wd = wd;
    in_b.wreg = 1'b1; in_b.inst = inst; in_b.ra = 32'h0000_0040 + {27'h0, wd};
    in_b.pc = in_b.pc + 32'd4;
  endtask

  task automatic drive_nop();
    drive(OP_NOP, SEL_NOP, 32'h0, 32'h0, 5'd0, 32'h0);
    in_b.wreg = 1'b0;
  endtask

  function automatic logic [31:0] rnd_val();
    logic [31:0] c[6] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 32'h1, 32'hFFFF_FFFF, 32'h0000_0100};
    return ($urandom_range(0, 2) == 0) ? c[$urandom_range(0, 5)] : $urandom;
  endfunction

  logic [7:0] ops[26] = '{OP_OR, OP_AND, OP_XOR, OP_NOR, OP_LUI, OP_SLL, OP_SRL, OP_SRA, OP_ADD,
    OP_ADDU, OP_SUB, OP_SUBU, OP_ADDI, OP_ADDIU, OP_SLT, OP_SLTU, OP_MOVZ, OP_MOVN, OP_LB, OP_LH,
    OP_LW, OP_SW, OP_SB, OP_JAL, OP_BAD, OP_NOP};
  logic [2:0] sels[26] = '{SEL_LOGIC, SEL_LOGIC, SEL_LOGIC, SEL_LOGIC, SEL_LOGIC, SEL_SHIFT,
    SEL_SHIFT, SEL_SHIFT, SEL_ARITH, SEL_ARITH, SEL_ARITH, SEL_ARITH, SEL_ARITH, SEL_ARITH,
    SEL_ARITH, SEL_ARITH, SEL_MOVE, SEL_MOVE, SEL_LS, SEL_LS, SEL_LS, SEL_LS, SEL_LS, SEL_JUMP,
    SEL_LOGIC, SEL_NOP};

  initial begin
    m_idex = bubble();
    m_mem  = exec(bubble());

    step();
    check("rst_ex_wdata", ex_wdata, 32'h0);
    check("rst_mem_wreg", 32'(mem_wreg), 32'h0);
    rst = 1'b0;

    drive(OP_OR, SEL_LOGIC, 32'h0000_1100, 32'h0000_0101, 5'd3, 32'h0);
    step();
    check("ori_ex_wdata", ex_wdata, 32'h0000_1101);
    drive_nop();
    step();
    check("ori_mem_wdata", mem_wdata, 32'h0000_1101);
    check("ori_mem_wreg", 32'(mem_wreg), 32'h1);

    drive(OP_ADD, SEL_ARITH, 32'h7FFF_FFFF, 32'h1, 5'd4, 32'h0);
    step();
    drive(OP_ADDU, SEL_ARITH, 32'h7FFF_FFFF, 32'h1, 5'd5, 32'h0);
    step();
    check("add_ovf", 32'(ovf), 32'h1);
    check("add_mem_wreg", 32'(mem_wreg), 32'h0);
    drive_nop();
    step();
    check("addu_wdata", mem_wdata, 32'h8000_0000);
    check("addu_wreg", 32'(mem_wreg), 32'h1);
    check("addu_ovf", 32'(ovf), 32'h0);

    drive(OP_AND, SEL_LOGIC, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd6, 32'h0);
    step();
    drive(OP_XOR, SEL_LOGIC, 32'h1234_5678, 32'hFFFF_0000, 5'd7, 32'h0);
    stall_id = 1'b1;
    step();
    stall_id = 1'b0;
    check("bubble_ex_wreg", 32'(ex_wreg), 32'h0);
    check("bubble_prior_mem", mem_wdata, 32'hF000_F000);

    drive(OP_ADDU, SEL_ARITH, 32'd5, 32'd6, 5'd7, 32'h0);
    step();
    drive(OP_SUBU, SEL_ARITH, 32'd10, 32'd3, 5'd8, 32'h0);
    step();
    drive(OP_XOR, SEL_LOGIC, 32'hAAAA_AAAA, 32'h5555_5555, 5'd9, 32'h0);
    stall_ex = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("hold_ex_wdata", ex_wdata, 32'd7);
      check("hold_mem_wdata", mem_wdata, 32'd11);
    end
    stall_ex = 1'b0;
    step();

    drive(OP_LW, SEL_LS, 32'h0000_0100, 32'h0, 5'd10, 32'h8C0A_FFFC);
    step();
    check("lw_is_load", 32'(ex_is_load), 32'h1);
    drive(OP_SRA, SEL_SHIFT, 32'd4, 32'h8000_0000, 5'd11, 32'h0);
    step();
    check("lw_mem_addr", mem_addr, 32'h0000_00FC);
    check("lw_mem_aluop", 32'(mem_aluop), 32'(OP_LW));
    check("sra_ex_wdata", ex_wdata, 32'hF800_0000);
    drive(OP_SLTU, SEL_ARITH, 32'hFFFF_FFFF, 32'h1, 5'd12, 32'h0);
    step();
    check("sltu_ex_wdata", ex_wdata, 32'h0);
    drive(OP_SLT, SEL_ARITH, 32'hFFFF_FFFF, 32'h1, 5'd13, 32'h0);
    step();
    check("slt_ex_wdata", ex_wdata, 32'h1);

    for (int pass = 0; pass < 2; pass++) begin
      drive(OP_OR, SEL_LOGIC, 32'h11, 32'h22, 5'd14, 32'h0);
      step();
      drive(OP_OR, SEL_LOGIC, 32'h44, 32'h88, 5'd15, 32'h0);
      step();
      if (pass == 0) flush = 1'b1; else rst = 1'b1;
      step();
      flush = 1'b0; rst = 1'b0;
      check("clr_ex_wdata", ex_wdata, 32'h0);
      check("clr_mem_wdata", mem_wdata, 32'h0);
      check("clr_mem_pc", mem_pc, 32'h0);
      drive(OP_OR, SEL_LOGIC, 32'h0F00, 32'h00F0, 5'd16, 32'h0);
      step();
      drive_nop();
      step();
      check("after_clr_wdata", mem_wdata, 32'h0FF0);
    end

    for (int n = 0; n < 600; n++) begin
      int j;
      j = $urandom_range(0, 25);
      drive(ops[j], sels[j], rnd_val(), rnd_val(), 5'($urandom), $urandom);
      in_b.wreg = 1'($urandom);
      stall_id = ($urandom_range(0, 9) == 0);
      stall_ex = ($urandom_range(0, 9) == 0);
      flush    = ($urandom_range(0, 39) == 0);
      rst      = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
